// File: rtl/sr_latch_monitor.sv
// Cycle-level response monitor for an SR latch: tracks the expected latch state,
// flags output mismatches and keeps saturating statistics. Optional: FIRST_ERR_CAPTURE_EN.
module sr_latch_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample_valid,
  input  logic             e,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  output logic             err_pulse,
  output logic             fail,
  output logic [1:0]       model_state,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic             first_err_valid,
  output logic [4:0]       first_err_vec,
  output logic [CNT_W-1:0] first_err_idx
`endif
);

  typedef enum logic [1:0] {
    UNKNOWN = 2'b00,
    KNOWN_0 = 2'b01,
    KNOWN_1 = 2'b10
  } state_t;

  state_t state;
  state_t next_state;
  logic   illegal;
  logic   mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The check is made against the state this sample moves the latch into.
  // Case-inequality keeps x/z on the latch outputs visible as an error.
  always_comb begin
    next_state = state;
    illegal    = e & s & r;
    if (illegal)
      next_state = UNKNOWN;
    else if (e & s)
      next_state = KNOWN_1;
    else if (e & r)
      next_state = KNOWN_0;

    mismatch = 1'b0;
    case (next_state)
      KNOWN_1: mismatch = (q !== 1'b1) || (q_bar !== 1'b0);
      KNOWN_0: mismatch = (q !== 1'b0) || (q_bar !== 1'b1);
      default: mismatch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNKNOWN;
      err_pulse   <= 1'b0;
      fail        <= 1'b0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      illegal_cnt <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_idx   <= '0;
`endif
    end else if (clr) begin
      state       <= UNKNOWN;
      err_pulse   <= 1'b0;
      fail        <= 1'b0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      illegal_cnt <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_idx   <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (sample_valid) begin
        state      <= next_state;
        sample_cnt <= sat_inc(sample_cnt);
        if (illegal)
          illegal_cnt <= sat_inc(illegal_cnt);
        if (mismatch) begin
          err_pulse <= 1'b1;
          fail      <= 1'b1;
          err_cnt   <= sat_inc(err_cnt);
`ifdef FIRST_ERR_CAPTURE_EN
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= {e, s, r, q, q_bar};
            first_err_idx   <= sample_cnt;
          end
`endif
        end
      end
    end
  end

  assign model_state = state;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Bench for sr_latch_monitor: vector table, hand-written corner sequences, and
// randomized samples checked against a behavioural model of the latch.
module tb_sr_latch_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, sample_valid, e, s, r, q, q_bar;
  logic        err_pulse, fail;
  logic [1:0]  model_state;
  logic [15:0] sample_cnt, err_cnt, illegal_cnt;
`ifdef FIRST_ERR_CAPTURE_EN
  logic        first_err_valid;
  logic [4:0]  first_err_vec;
  logic [15:0] first_err_idx;
`endif

  logic        clr4, sv4, e4, s4, r4, q4, qb4;
  logic        err_pulse4, fail4;
  logic [1:0]  model_state4;
  logic [3:0]  sample_cnt4, err_cnt4, illegal_cnt4;
`ifdef FIRST_ERR_CAPTURE_EN
  logic        fev4;
  logic [4:0]  fevec4;
  logic [3:0]  feidx4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_monitor #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sample_valid(sample_valid),
    .e(e), .s(s), .r(r), .q(q), .q_bar(q_bar),
    .err_pulse(err_pulse), .fail(fail), .model_state(model_state),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .illegal_cnt(illegal_cnt)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .first_err_idx(first_err_idx)
`endif
  );

  sr_latch_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .sample_valid(sv4),
    .e(e4), .s(s4), .r(r4), .q(q4), .q_bar(qb4),
    .err_pulse(err_pulse4), .fail(fail4), .model_state(model_state4),
    .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .illegal_cnt(illegal_cnt4)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_valid(fev4), .first_err_vec(fevec4), .first_err_idx(feidx4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one sample, let one rising edge pass, return #1 after it.
  task automatic step(input logic vc, input logic vv, input logic ve, input logic vs,
                      input logic vr, input logic vq, input logic vqb);
    clr = vc; sample_valid = vv; e = ve; s = vs; r = vr; q = vq; q_bar = vqb;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic vc, input logic vv, input logic ve, input logic vs,
                       input logic vr, input logic vq, input logic vqb);
    clr4 = vc; sv4 = vv; e4 = ve; s4 = vs; r4 = vr; q4 = vq; qb4 = vqb;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: latch value as -1 (unknown), 0 or 1, counters as ints.
  int m_val, m_samples, m_errs, m_illegal;
  bit m_fail, m_pulse;

  function automatic int predict(int cur, logic ve, logic vs, logic vr);
    if (ve === 1'b1 && vs === 1'b1 && vr === 1'b1) return -1;
    if (ve === 1'b1 && vs === 1'b1) return 1;
    if (ve === 1'b1 && vr === 1'b1) return 0;
    return cur;
  endfunction

  task automatic model_clear();
    m_val = -1; m_samples = 0; m_errs = 0; m_illegal = 0; m_fail = 0; m_pulse = 0;
  endtask

  task automatic model_sample(input logic vc, input logic vv, input logic ve, input logic vs,
                              input logic vr, input logic vq, input logic vqb);
    bit bad;
    if (vc) begin
      model_clear();
      return;
    end
    m_pulse = 0;
    if (!vv) return;
    m_val = predict(m_val, ve, vs, vr);
    if (ve && vs && vr) m_illegal = (m_illegal < 65535) ? m_illegal + 1 : m_illegal;
    m_samples = (m_samples < 65535) ? m_samples + 1 : m_samples;
    bad = (m_val == 1 && !(vq === 1'b1 && vqb === 1'b0)) ||
          (m_val == 0 && !(vq === 1'b0 && vqb === 1'b1));
    if (bad) begin
      m_pulse = 1;
      m_fail  = 1;
      m_errs  = (m_errs < 65535) ? m_errs + 1 : m_errs;
    end
  endtask

  function automatic logic [1:0] enc(int v);
    return (v == 1) ? 2'b10 : (v == 0) ? 2'b01 : 2'b00;
  endfunction

  typedef struct {
    logic       c, ve, vs, vr, vq, vqb;
    logic [1:0] st;
    logic       ep;
  } vec_t;

  vec_t tbl[14];

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].c, 1'b1, tbl[i].ve, tbl[i].vs, tbl[i].vr, tbl[i].vq, tbl[i].vqb);
      check($sformatf("row%0d state", i), 32'(model_state), 32'(tbl[i].st));
      check($sformatf("row%0d err_pulse", i), 32'(err_pulse), 32'(tbl[i].ep));
    end
  endtask

  initial begin
    // Sweep with a well-behaved latch.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    // Set with the latch stuck at 0.
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
    // clr with a valid sample, illegal input, then x outputs while unknown.
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'bx, 1'bx, 2'b00, 1'b0};
    // Set, then r while disabled must hold.
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0};

    rst_n = 1'b0;
    clr = 0; sample_valid = 0; e = 0; s = 0; r = 0; q = 0; q_bar = 1;
    clr4 = 0; sv4 = 0; e4 = 0; s4 = 0; r4 = 0; q4 = 0; qb4 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(model_state), 32'd0);
    check("reset fail", 32'(fail), 32'd0);
    check("reset err_pulse", 32'(err_pulse), 32'd0);
    check("reset sample_cnt", 32'(sample_cnt), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1);

    apply_rows(0, 7);
    check("sweep sample_cnt", 32'(sample_cnt), 32'd8);
    check("sweep illegal_cnt", 32'(illegal_cnt), 32'd1);
    check("sweep err_cnt", 32'(err_cnt), 32'd0);
    check("sweep fail", 32'(fail), 32'd0);

    apply_rows(8, 8);
    check("stuck err_cnt", 32'(err_cnt), 32'd1);
    check("stuck fail", 32'(fail), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("pulse one cycle", 32'(err_pulse), 32'd0);
    check("fail sticky", 32'(fail), 32'd1);

    apply_rows(9, 11);
    check("unknown illegal_cnt", 32'(illegal_cnt), 32'd1);
    check("unknown err_cnt", 32'(err_cnt), 32'd0);
    check("unknown sample_cnt", 32'(sample_cnt), 32'd2);
    check("clr fail", 32'(fail), 32'd0);

    apply_rows(12, 13);
    check("hold err_cnt", 32'(err_cnt), 32'd0);

    // Saturation on the narrow instance.
    for (int i = 0; i < 20; i++) step4(0, 1, 1, 1, 0, 0, 1);
    check("sat err_cnt", 32'(err_cnt4), 32'd15);
    check("sat sample_cnt", 32'(sample_cnt4), 32'd15);
    step4(1, 1, 1, 1, 0, 0, 1);
    check("clr4 err_cnt", 32'(err_cnt4), 32'd0);
    check("clr4 sample_cnt", 32'(sample_cnt4), 32'd0);
    check("clr4 illegal_cnt", 32'(illegal_cnt4), 32'd0);
    check("clr4 fail", 32'(fail4), 32'd0);
    check("clr4 state", 32'(model_state4), 32'd0);
    check("clr4 err_pulse", 32'(err_pulse4), 32'd0);
    step4(0, 0, 0, 0, 0, 0, 1);

`ifdef FIRST_ERR_CAPTURE_EN
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 1, 1);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    check("first_err_valid", 32'(first_err_valid), 32'd1);
    check("first_err_idx", 32'(first_err_idx), 32'd3);
    check("first_err_vec", 32'(first_err_vec), 32'b11001);
    check("two errors", 32'(err_cnt), 32'd2);
`endif

    // Randomized run against the behavioural model.
    step(1, 0, 0, 0, 0, 0, 1);
    model_clear();
    for (int n = 0; n < 400; n++) begin
      logic vc, vv, ve, vs, vr, vq, vqb;
      int pred, pick;
      vc = ($urandom_range(0, 39) == 0);
      vv = ($urandom_range(0, 9) < 8);
      ve = 1'($urandom); vs = 1'($urandom); vr = 1'($urandom);
      pred = predict(m_val, ve, vs, vr);
      pick = $urandom_range(0, 99);
      if (pred < 0) begin
        vq = 1'($urandom); vqb = 1'($urandom);
      end else begin
        vq = 1'(pred); vqb = ~1'(pred);
      end
      if (pick >= 75 && pick < 90) vq = ~vq;
      else if (pick >= 90) vq = 1'bx;
      step(vc, vv, ve, vs, vr, vq, vqb);
      model_sample(vc, vv, ve, vs, vr, vq, vqb);
      check("rnd state", 32'(model_state), 32'(enc(m_val)));
      check("rnd err_pulse", 32'(err_pulse), 32'(m_pulse));
      check("rnd fail", 32'(fail), 32'(m_fail));
      check("rnd sample_cnt", 32'(sample_cnt), 32'(m_samples));
      check("rnd err_cnt", 32'(err_cnt), 32'(m_errs));
      check("rnd illegal_cnt", 32'(illegal_cnt), 32'(m_illegal));
    end

    // Asynchronous reset in the middle of a cycle.
    step(0, 1, 1, 1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async fail", 32'(fail), 32'd0);
    check("async sample_cnt", 32'(sample_cnt), 32'd0);
    check("async err_cnt", 32'(err_cnt), 32'd0);
    check("async state", 32'(model_state), 32'd0);
`ifdef FIRST_ERR_CAPTURE_EN
    check("async first_err_valid", 32'(first_err_valid), 32'd0);
    check("async first_err_idx", 32'(first_err_idx), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
